// File: rtl/qif_pkg.sv
// Shared fixed-point constants and the signed 8-bit saturation helper used by the
// synaptic current stage and the QIF neuron membrane clamp.
package qif_pkg;

    localparam int DATA_W = 8;
    localparam int I_MAX  = 127;
    localparam int I_MIN  = -128;

    typedef struct packed {
        logic signed [DATA_W-1:0] val;
        logic                     clip;
    } sat8_t;

    function automatic sat8_t sat8(input logic signed [11:0] v);
        sat8_t r;
        if (v > 12'(I_MAX)) begin
            r.val  = 8'(I_MAX);
            r.clip = 1'b1;
        end else if (v < 12'(I_MIN)) begin
            r.val  = 8'(I_MIN);
            r.clip = 1'b1;
        end else begin
            r.val  = v[DATA_W-1:0];
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/syn_weight_rf.sv
// Synaptic weight register file: one write port, all weights read in parallel.
module syn_weight_rf
    import qif_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    parameter int unsigned AW   = $clog2(N_IN)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [AW-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    output logic [N_IN-1:0][DATA_W-1:0]    w
);

    logic addr_ok;

    // Indices past N_IN exist only when N_IN is not a power of two; drop them.
    assign addr_ok = (32'(wr_addr) < N_IN);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            w <= '0;
        end else if (wr_en && addr_ok) begin
            w[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/syn_current_integrator.sv
// Leaky synaptic current integrator: weighted spike sum plus periodic exponential decay,
// saturated to signed 8 bits and registered as I_syn for the QIF neuron.
module syn_current_integrator
    import qif_pkg::*;
#(
    parameter int unsigned N_IN         = 4,
    parameter int unsigned DECAY_SHIFT  = 3,
    parameter int unsigned DECAY_PERIOD = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic [N_IN-1:0]                spike_in,
    input  logic                           w_wr_en,
    input  logic [$clog2(N_IN)-1:0]        w_wr_addr,
    input  logic [DATA_W-1:0]              w_wr_data,
    output logic signed [DATA_W-1:0]       I_syn,
    output logic                           sat
);

    localparam int unsigned AW     = $clog2(N_IN);
    localparam int unsigned SUM_W  = DATA_W + AW;
    localparam int unsigned NXT_W  = (SUM_W + 1 > 12) ? SUM_W + 1 : 12;
    localparam int unsigned PCNT_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

    localparam logic signed [NXT_W-1:0] NXT12_MAX = NXT_W'(2047);
    localparam logic signed [NXT_W-1:0] NXT12_MIN = NXT_W'(-2048);

    logic [N_IN-1:0][DATA_W-1:0] w;

    logic signed [DATA_W-1:0] acc_q;
    logic                     sat_q;
    logic [PCNT_W-1:0]        pcnt_q, pcnt_d;
    logic                     tick;

    logic signed [SUM_W-1:0]  sum;
    logic signed [DATA_W:0]   acc_ext;
    logic [DATA_W:0]          mag, shr;
    logic signed [DATA_W:0]   d;
    logic signed [NXT_W-1:0]  nxt;
    logic signed [11:0]       nxt12;
    sat8_t                    res;

    syn_weight_rf #(
        .N_IN (N_IN),
        .AW   (AW)
    ) u_weight_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_addr),
        .wr_data (w_wr_data),
        .w       (w)
    );

    always_comb begin
        tick   = (pcnt_q == PCNT_W'(DECAY_PERIOD - 1));
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (spike_in[i]) begin
                sum = sum + SUM_W'($signed(w[i]));
            end
        end
    end

    // Decay magnitude is floored at 1 so small currents of either sign reach exactly zero.
    always_comb begin
        acc_ext = {acc_q[DATA_W-1], acc_q};
        mag     = acc_q[DATA_W-1] ? -acc_ext : acc_ext;
        shr     = mag >> DECAY_SHIFT;
        if (shr == '0) begin
            shr = (DATA_W+1)'(1);
        end
        d = '0;
        if (tick && (acc_q != '0)) begin
            d = acc_q[DATA_W-1] ? -$signed(shr) : $signed(shr);
        end
    end

    always_comb begin
        nxt = NXT_W'(acc_q) - NXT_W'(d) + NXT_W'(sum);
        if (nxt > NXT12_MAX) begin
            nxt12 = 12'sh7ff;
        end else if (nxt < NXT12_MIN) begin
            nxt12 = 12'sh800;
        end else begin
            nxt12 = nxt[11:0];
        end
        res = sat8(nxt12);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc_q  <= '0;
            sat_q  <= 1'b0;
            pcnt_q <= '0;
        end else if (clr) begin
            acc_q  <= '0;
            sat_q  <= 1'b0;
            pcnt_q <= '0;
        end else begin
            acc_q  <= res.val;
            sat_q  <= res.clip;
            pcnt_q <= pcnt_d;
        end
    end

    assign I_syn = acc_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_syn_current_integrator.sv
// Directed-vector bench for syn_current_integrator with hand-computed expectations.
module tb_syn_current_integrator;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic [3:0]        spike_in;
    logic              w_wr_en;
    logic [1:0]        w_wr_addr;
    logic [7:0]        w_wr_data;
    logic signed [7:0] I_syn;
    logic              sat;

    int vectors;
    int miscompares;

    syn_current_integrator #(
        .N_IN         (4),
        .DECAY_SHIFT  (3),
        .DECAY_PERIOD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .spike_in  (spike_in),
        .w_wr_en   (w_wr_en),
        .w_wr_addr (w_wr_addr),
        .w_wr_data (w_wr_data),
        .I_syn     (I_syn),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int idx, input logic signed [7:0] val);
        w_wr_en   = 1'b1;
        w_wr_addr = 2'(idx);
        w_wr_data = val;
        step();
        w_wr_en   = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) step();
        vectors++;
        if (I_syn !== 8'sd0 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: I_syn=%0d sat=%0b, want 0/0", I_syn, sat);
        end
        rst_n = 1'b0;
    endtask

    task automatic test_single_spike();
        write_w(0, 8'sd40);
        do_clr();
        spike_in = 4'b0001;
        step();
        spike_in = 4'b0000;
        vectors++;
        if (I_syn !== 8'sd40 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL single_spike: I_syn=%0d sat=%0b, want 40/0", I_syn, sat);
        end
    endtask

    task automatic test_decay();
        int seq[4] = '{56, 49, 43, 38};
        int expv;
        int dec;
        write_w(0, 8'sd64);
        do_clr();
        spike_in = 4'b0001;
        step();
        spike_in = 4'b0000;
        vectors++;
        if (I_syn !== 8'sd64) begin
            miscompares++;
            $display("FAIL decay_load: I_syn=%0d, want 64", I_syn);
        end
        expv = 64;
        repeat (2) step();
        for (int t = 0; t < 29; t++) begin
            step();
            if (t < 4) begin
                expv = seq[t];
            end else if (expv > 0) begin
                dec  = expv >>> 3;
                expv = expv - ((dec > 0) ? dec : 1);
            end
            vectors++;
            if (I_syn !== 8'(expv) || sat !== 1'b0) begin
                miscompares++;
                $display("FAIL decay_tick%0d: I_syn=%0d sat=%0b, want %0d/0", t, I_syn, sat, expv);
            end
            repeat (3) step();
        end
    endtask

    task automatic test_neg_decay();
        write_w(3, -8'sd20);
        do_clr();
        spike_in = 4'b1000;
        step();
        spike_in = 4'b0000;
        vectors++;
        if (I_syn !== -8'sd20) begin
            miscompares++;
            $display("FAIL neg_load: I_syn=%0d, want -20", I_syn);
        end
        repeat (3) step();
        vectors++;
        if (I_syn !== -8'sd18) begin
            miscompares++;
            $display("FAIL neg_decay: I_syn=%0d, want -18", I_syn);
        end
        write_w(3, -8'sd1);
        do_clr();
        spike_in = 4'b1000;
        step();
        spike_in = 4'b0000;
        vectors++;
        if (I_syn !== -8'sd1) begin
            miscompares++;
            $display("FAIL minus_one_load: I_syn=%0d, want -1", I_syn);
        end
        repeat (3) step();
        vectors++;
        if (I_syn !== 8'sd0) begin
            miscompares++;
            $display("FAIL minus_one_decay: I_syn=%0d, want 0", I_syn);
        end
        repeat (4) step();
        vectors++;
        if (I_syn !== 8'sd0) begin
            miscompares++;
            $display("FAIL zero_hold: I_syn=%0d, want 0", I_syn);
        end
    endtask

    task automatic test_saturation();
        write_w(0, 8'sd127);
        write_w(1, 8'sd127);
        do_clr();
        spike_in = 4'b0011;
        step();
        spike_in = 4'b0000;
        vectors++;
        if (I_syn !== 8'sd127 || sat !== 1'b1) begin
            miscompares++;
            $display("FAIL pos_sat: I_syn=%0d sat=%0b, want 127/1", I_syn, sat);
        end
        step();
        vectors++;
        if (I_syn !== 8'sd127 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL pos_hold: I_syn=%0d sat=%0b, want 127/0", I_syn, sat);
        end
        write_w(2, -8'sd100);
        do_clr();
        spike_in = 4'b0100;
        step();
        vectors++;
        if (I_syn !== -8'sd100 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL neg_first: I_syn=%0d sat=%0b, want -100/0", I_syn, sat);
        end
        step();
        spike_in = 4'b0000;
        vectors++;
        if (I_syn !== -8'sd128 || sat !== 1'b1) begin
            miscompares++;
            $display("FAIL neg_sat: I_syn=%0d sat=%0b, want -128/1", I_syn, sat);
        end
        step();
        vectors++;
        if (I_syn !== -8'sd128 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL neg_hold: I_syn=%0d sat=%0b, want -128/0", I_syn, sat);
        end
        step();
        vectors++;
        if (I_syn !== -8'sd112 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL neg_sat_decay: I_syn=%0d sat=%0b, want -112/0", I_syn, sat);
        end
    endtask

    task automatic test_write_collision();
        write_w(1, 8'sd10);
        do_clr();
        w_wr_en   = 1'b1;
        w_wr_addr = 2'd1;
        w_wr_data = -8'sd20;
        spike_in  = 4'b0010;
        step();
        w_wr_en   = 1'b0;
        vectors++;
        if (I_syn !== 8'sd10) begin
            miscompares++;
            $display("FAIL collide_old_weight: I_syn=%0d, want 10", I_syn);
        end
        step();
        spike_in = 4'b0000;
        vectors++;
        if (I_syn !== -8'sd10) begin
            miscompares++;
            $display("FAIL collide_new_weight: I_syn=%0d, want -10", I_syn);
        end
    endtask

    task automatic test_clr_collision();
        write_w(0, 8'sd127);
        write_w(1, 8'sd127);
        do_clr();
        repeat (2) step();
        spike_in = 4'b0011;
        step();
        vectors++;
        if (I_syn !== 8'sd127 || sat !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_pre: I_syn=%0d sat=%0b, want 127/1", I_syn, sat);
        end
        clr = 1'b1;
        step();
        clr      = 1'b0;
        spike_in = 4'b0001;
        vectors++;
        if (I_syn !== 8'sd0 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_priority: I_syn=%0d sat=%0b, want 0/0", I_syn, sat);
        end
        step();
        spike_in = 4'b0000;
        vectors++;
        if (I_syn !== 8'sd127 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_after_spike: I_syn=%0d sat=%0b, want 127/0", I_syn, sat);
        end
        repeat (2) step();
        vectors++;
        if (I_syn !== 8'sd127) begin
            miscompares++;
            $display("FAIL clr_no_early_tick: I_syn=%0d, want 127", I_syn);
        end
        step();
        vectors++;
        if (I_syn !== 8'sd112) begin
            miscompares++;
            $display("FAIL clr_tick_phase: I_syn=%0d, want 112", I_syn);
        end
    endtask

    task automatic test_reset_midrun();
        write_w(0, 8'sd50);
        do_clr();
        spike_in = 4'b0001;
        step();
        spike_in = 4'b0000;
        vectors++;
        if (I_syn !== 8'sd50) begin
            miscompares++;
            $display("FAIL midrun_load: I_syn=%0d, want 50", I_syn);
        end
        #2;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (I_syn !== 8'sd0 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: I_syn=%0d sat=%0b, want 0/0", I_syn, sat);
        end
        step();
        rst_n    = 1'b0;
        spike_in = 4'b1111;
        step();
        spike_in = 4'b0000;
        vectors++;
        if (I_syn !== 8'sd0) begin
            miscompares++;
            $display("FAIL weights_cleared: I_syn=%0d, want 0", I_syn);
        end
        write_w(0, 8'sd64);
        spike_in = 4'b0001;
        step();
        spike_in = 4'b0000;
        vectors++;
        if (I_syn !== 8'sd64) begin
            miscompares++;
            $display("FAIL post_reset_load: I_syn=%0d, want 64", I_syn);
        end
        step();
        vectors++;
        if (I_syn !== 8'sd56) begin
            miscompares++;
            $display("FAIL post_reset_first_tick: I_syn=%0d, want 56", I_syn);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        clr         = 1'b0;
        spike_in    = 4'b0000;
        w_wr_en     = 1'b0;
        w_wr_addr   = 2'd0;
        w_wr_data   = 8'd0;

        test_reset();
        test_single_spike();
        test_decay();
        test_neg_decay();
        test_saturation();
        test_write_collision();
        test_clr_collision();
        test_reset_midrun();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/syn_current_integrator.md
# syn_current_integrator

Synaptic current stage directly upstream of the QIF neuron. Converts per-input spike pulses into the 8-bit signed synaptic current `I_syn` that drives the neuron's membrane update. Spikes are weighted by a programmable weight register file, summed, added to a leaky current accumulator with periodic exponential decay, and saturated to the signed 8-bit range.

## Interface
- `N_IN`, 4, number of spike inputs (2..16).
- `DECAY_SHIFT`, 3, decay strength; each decay event removes `acc >> DECAY_SHIFT` (magnitude).
- `DECAY_PERIOD`, 4, cycles between decay events (≥1).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-high.
- `clr`  in  1  synchronous clear of the accumulator and prescaler; weights are kept.
- `spike_in`  in  N_IN  one-cycle spike pulses, one bit per presynaptic input.
- `w_wr_en`  in  1  weight write strobe.
- `w_wr_addr`  in  clog2(N_IN)  weight index; writes to indices ≥ N_IN are ignored.
- `w_wr_data`  in  8  signed weight value.
- `I_syn`  out  8  signed synaptic current, registered; feeds the neuron `I_syn` input.
- `sat`  out  1  registered; high when the current `I_syn` value was clipped.

## Operation
- Weight RF: N_IN × 8-bit signed, reset to 0. A write takes effect the cycle after `w_wr_en`. A spike on the same index in the write cycle uses the old weight.
- Spike sum: signed sum of `w[i]` for every set `spike_in[i]`. Width is 8+clog2(N_IN) bits, so there is no overflow.
- Prescaler `pcnt`: resets to 0 and increments each cycle. At `DECAY_PERIOD-1` it asserts `tick` and wraps to 0.
- Decay term `d`, only when `tick` is high (else 0):
  - acc > 0: `d = max(acc >> DECAY_SHIFT, 1)`.
  - acc < 0: `d = -max((-acc) >> DECAY_SHIFT, 1)`.
  - acc = 0: `d = 0`.
  - Decay always moves toward zero and reaches exactly 0 with no limit cycle at -1.
- Next value: `nxt = acc - d + sum`, computed at 12 bits, then saturated:
  - Clipped to 127 or -128.
  - `sat_nxt = 1` iff clipping occurred.
- Register update: `acc <= sat(nxt)`, `sat <= sat_nxt`. `I_syn` is `acc`.
- `clr`: acc ← 0, sat ← 0, pcnt ← 0. It has priority over spikes and decay in the same cycle.
- Reset (async, any time incl. mid-accumulation): acc, I_syn, sat, pcnt and all weights ← 0.

## Timing
- Spike-to-`I_syn` latency is 1 cycle: spike sampled at edge k, contribution visible after edge k.
- Decay and spike in the same cycle are both applied in one update. The decay is computed from the pre-update acc.
- Weight write is visible to spikes sampled at the next edge.
- `sat` is aligned with the `I_syn` value it describes.
- No handshake: spikes are level-sampled every cycle, and a spike held high for n cycles counts n times.
- Reset deassertion: first tick occurs DECAY_PERIOD cycles after the first rising edge.

## Structure
- Shared package `qif_pkg`:
  - `DATA_W = 8`, `I_MAX = 127`, `I_MIN = -128`.
  - Function `sat8(logic signed [11:0])` returning value plus clip flag.
  - The package is reused by the QIF neuron for V_mem clamping.
- Sub-module `syn_weight_rf`: N_IN×8 register file with write port and parallel read of all weights.
- Top holds the adder tree, prescaler, decay logic and output register.

## Test plan
- Reset: hold rst_n=1 mid-run with acc=50 → I_syn=0, sat=0 immediately (async). All weights read 0 after release.
- Single spike: w[0]=40, spike_in=0001 at a non-tick cycle → I_syn=40 next cycle, sat=0.
- Decay: acc=64, no spikes, ticks every 4 cycles → sequence 56, 49, 43, 38, …, then …, 2, 1, 0; stays 0.
- Positive saturation: w[0]=w[1]=127, spike_in=0011 → I_syn=127, sat=1. Negative case: w[2]=-100 spiked twice → -128, sat=1.
- Write/spike collision: w[1]=10, then same cycle write w[1]=-20 and spike_in=0010 → +10 applied. Next spike applies -20.
- clr collision: clr with spike and tick in the same cycle → I_syn=0, sat=0, next tick 4 cycles later.
